seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 8: number of multiplexed digits, range 1..16.
REQ-002 SHALL have parameter BRIGHT_W, default 2: slot counter width; each digit slot lasts 2^BRIGHT_W clocks.
REQ-003 SHALL have parameter BLINK_FRAMES, default 4: frames per blink phase.
REQ-004 SHALL have port clk_1khz  in  1  scan clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have port data_i  in  4*DIGITS  hex nibbles; digit k = data_i[4k+3:4k], digit 0 rightmost.
REQ-007 SHALL have port dp_i  in  DIGITS  decimal point request per digit, 1 = lit.
REQ-008 SHALL have port load_i  in  1  single-cycle strobe capturing data_i/dp_i.
REQ-009 SHALL have port bright_i  in  BRIGHT_W  on-clocks per slot minus 1.
REQ-010 SHALL have port blink_i  in  DIGITS  per-digit blink enable.
REQ-011 SHALL have port blank_lz_i  in  1  leading-zero suppression enable.
REQ-012 SHALL have port seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-013 SHALL have port dp_o  out  1  decimal point, active-low, registered.
REQ-014 SHALL have port led_en_o  out  DIGITS  digit enables, active-low, one-cold, registered.
REQ-015 SHALL have port frame_o  out  1  one-clock pulse on the last clock of each frame.

Function
REQ-016 Slot counter SHALL count 0..2^BRIGHT_W-1; at wrap, digit index SHALL advance 0,1,..,DIGITS-1,0.
REQ-017 Digit index, nibble select and dp select SHALL share one register stage, so led_en_o, seg_o and dp_o always refer to the same digit; no index/nibble skew is permitted.
REQ-018 Outputs SHALL lag the internal index by exactly 1 clock.
REQ-019 led_en_o[idx] SHALL be 0 only while slot count <= bright_i; all other clocks SHALL be all-ones (dark).
REQ-020 seg_o SHALL carry the hex 0-F glyph of the displayed nibble; A-F in the b,C,d,E,F style with lowercase b and d.
REQ-021 load_i SHALL capture data_i/dp_i into a pending register and set a pending flag; a second load before apply SHALL overwrite pending.
REQ-022 Pending SHALL transfer to the display register on the frame-wrap clock (index DIGITS-1 to 0) and clear the flag, so no frame shows mixed data.
REQ-023 load_i on the frame-wrap clock SHALL put data_i directly into the display register and leave pending clear.
REQ-024 With blank_lz_i=1, zero digits above the highest non-zero digit SHALL show seg_o=7'h7F; digit 0 is never suppressed; dp_o is unaffected.
REQ-025 Blink phase SHALL toggle every BLINK_FRAMES frames; while phase=off, digits with blink_i set SHALL show seg_o=7'h7F and dp_o=1.
REQ-026 bright_i SHALL be sampled each clock; a change SHALL take effect on the next slot compare.

Reset
REQ-027 On rst=1, without waiting for a clock: led_en_o all-ones, seg_o 7'h7F, dp_o 1, frame_o 0.
REQ-028 On rst=1: index, slot counter, blink counter and phase (on) SHALL clear, and display register, pending register and pending flag SHALL clear.
REQ-029 First clock after release SHALL start at digit 0, slot 0.
REQ-030 Reset mid-frame SHALL discard any pending load.

Structure
REQ-031 Package seg_pkg SHALL hold the 16-entry glyph table, the blank pattern 7'h7F and the parameter defaults.
REQ-032 Hex-to-glyph decode SHALL be sub-module seg_hex_decode: 4-bit input, 7-bit active-low output, combinational.
REQ-033 Blanking, dp and enable gating SHALL be applied before the output register.

Verification (DIGITS=4, BRIGHT_W=2, BLINK_FRAMES=2)
REQ-034 Reset, load 16'h1234, bright_i=3 -> led_en_o cycles 1110,1101,1011,0111, each 4 clocks; seg_o shows 4,3,2,1 aligned with its enable; frame_o pulses every 16 clocks.
REQ-035 bright_i=0 -> each enable is low 1 of 4 clocks and dark the other 3.
REQ-036 load 16'hAAAA mid-frame -> current frame completes with old data; next frame shows A on all digits; load on the wrap clock -> new data appears in the immediately following frame.
REQ-037 blank_lz_i=1, data 16'h0050 -> digits 3 and 2 show 7'h7F, digit 1 shows 5, digit 0 shows 0; data 16'h0000 -> only digit 0 lit, showing 0.
REQ-038 blink_i=4'b0001, dp_i=4'b0001 -> digit 0 segments and dp dark for 2 frames, then lit for 2 frames, repeating; other digits are steady.
REQ-039 Assert rst mid-slot with a load pending -> outputs dark immediately; after release, display shows 0000 and the pending data never appears.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int DIGITS_DEF       = 8;
    localparam int BRIGHT_W_DEF     = 2;
    localparam int BLINK_FRAMES_DEF = 4;

    localparam logic [6:0] BLANK = 7'h7F;

    // Entry 15 first; A-F drawn as A,b,C,d,E,F
    localparam logic [15:0][6:0] GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
// Output bit order is {g,f,e,d,c,b,a}.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = GLYPH[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with brightness, blink,
// leading-zero blanking and frame-aligned double-buffered loads.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS       = DIGITS_DEF,
    parameter int BRIGHT_W     = BRIGHT_W_DEF,
    parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
    input  logic                  clk_1khz,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic                  load_i,
    input  logic [BRIGHT_W-1:0]   bright_i,
    input  logic [DIGITS-1:0]     blink_i,
    input  logic                  blank_lz_i,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     led_en_o,
    output logic                  frame_o
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [IDX_W-1:0] LAST     = IDX_W'(DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic [IDX_W-1:0]       idx;
    logic [BRIGHT_W-1:0]    slot;
    logic [DIGITS-1:0][3:0] disp;
    logic [DIGITS-1:0][3:0] pend;
    logic [DIGITS-1:0]      disp_dp;
    logic [DIGITS-1:0]      pend_dp;
    logic                   pend_vld;
    logic [BLK_W-1:0]       blk_cnt;
    logic                   phase;

    logic                   slot_end;
    logic                   wrap;
    logic [3:0]             nib;
    logic [6:0]             glyph;
    logic [DIGITS-1:0]      lz;
    logic                   zero_above;
    logic                   blink_off;
    logic                   suppress;
    logic                   lit;

    assign slot_end = &slot;
    assign wrap     = slot_end && (idx == LAST);

    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            idx  <= '0;
            slot <= '0;
        end else begin
            slot <= slot + 1'b1;
            if (slot_end) begin
                idx <= (idx == LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // New data only lands on the frame boundary so a frame never mixes values
    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            disp     <= '0;
            disp_dp  <= '0;
            pend     <= '0;
            pend_dp  <= '0;
            pend_vld <= 1'b0;
        end else if (wrap) begin
            pend_vld <= 1'b0;
            if (load_i) begin
                disp    <= data_i;
                disp_dp <= dp_i;
            end else if (pend_vld) begin
                disp    <= pend;
                disp_dp <= pend_dp;
            end
        end else if (load_i) begin
            pend     <= data_i;
            pend_dp  <= dp_i;
            pend_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            blk_cnt <= '0;
            phase   <= 1'b1;
        end else if (wrap) begin
            if (blk_cnt == BLK_LAST) begin
                blk_cnt <= '0;
                phase   <= ~phase;
            end else begin
                blk_cnt <= blk_cnt + 1'b1;
            end
        end
    end

    // lz[k] is set when digit k and everything above it are zero
    always_comb begin
        lz         = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above && (disp[k] == 4'h0);
            lz[k]      = zero_above;
        end
    end

    assign nib       = disp[idx];
    assign blink_off = !phase && blink_i[idx];
    assign suppress  = blank_lz_i && lz[idx];
    assign lit       = (slot <= bright_i);

    seg_hex_decode u_dec (
        .hex (nib),
        .seg (glyph)
    );

    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            led_en_o <= '1;
            seg_o    <= BLANK;
            dp_o     <= 1'b1;
            frame_o  <= 1'b0;
        end else begin
            led_en_o <= lit ? ~(DIGITS'(1) << idx) : '1;
            seg_o    <= (blink_off || suppress) ? BLANK : glyph;
            dp_o     <= blink_off ? 1'b1 : ~disp_dp[idx];
            frame_o  <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with DIGITS=4, BRIGHT_W=2,
// BLINK_FRAMES=2, driven by directed and random stimulus.
module tb_seg_scan_ctrl;

    localparam int D  = 4;
    localparam int BW = 2;
    localparam int BF = 2;

    logic          clk_1khz = 1'b0;
    logic          rst;
    logic [15:0]   data_i;
    logic [3:0]    dp_i;
    logic          load_i;
    logic [1:0]    bright_i;
    logic [3:0]    blink_i;
    logic          blank_lz_i;
    logic [6:0]    seg_o;
    logic          dp_o;
    logic [3:0]    led_en_o;
    logic          frame_o;

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] en;
        logic       fr;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int checks = 0;
    int errors = 0;
    int n = 0;

    logic [15:0] shown, pdata;
    logic [3:0]  sdp, pdp;
    bit          pvld;

    // Active-high abcdefg (bit0 = a) reference shapes
    logic [6:0] hi_tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    seg_scan_ctrl #(
        .DIGITS       (D),
        .BRIGHT_W     (BW),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk_1khz   (clk_1khz),
        .rst        (rst),
        .data_i     (data_i),
        .dp_i       (dp_i),
        .load_i     (load_i),
        .bright_i   (bright_i),
        .blink_i    (blink_i),
        .blank_lz_i (blank_lz_i),
        .seg_o      (seg_o),
        .dp_o       (dp_o),
        .led_en_o   (led_en_o),
        .frame_o    (frame_o)
    );

    always #5 clk_1khz = ~clk_1khz;

    // Reference model: position within the scan derives from edge count
    initial begin
        forever begin
            @(posedge clk_1khz or posedge rst);
            if (rst) begin
                n     = 0;
                shown = '0;
                sdp   = '0;
                pdata = '0;
                pdp   = '0;
                pvld  = 0;
                q.delete();
            end else begin
                int   pos, dig, slot, hi;
                bit   off;
                exp_t e;
                pos = n % 16;
                dig = pos / 4;
                slot = pos % 4;
                off = ((((n / 16) / BF) % 2) == 1) && blink_i[dig];
                hi = 0;
                for (int k = 0; k < D; k++)
                    if (shown[4*k +: 4] != 4'h0) hi = k;
                e.en  = (slot <= int'(bright_i)) ? ~(4'b1 << dig) : 4'hF;
                e.seg = (off || (blank_lz_i && dig > hi)) ? 7'h7F
                        : ~hi_tbl[shown[4*dig +: 4]];
                e.dp  = off ? 1'b1 : ~sdp[dig];
                e.fr  = (pos == 15);
                q.push_back(e);
                if (pos == 15) begin
                    if (load_i) begin
                        shown = data_i;
                        sdp   = dp_i;
                        pvld  = 0;
                    end else if (pvld) begin
                        shown = pdata;
                        sdp   = pdp;
                        pvld  = 0;
                    end
                end else if (load_i) begin
                    pdata = data_i;
                    pdp   = dp_i;
                    pvld  = 1;
                end
                n++;
            end
        end
    end

    // Monitor: one expected entry per output clock
    initial begin
        forever begin
            @(negedge clk_1khz);
            if (!rst && q.size() > 0) begin
                m = q.pop_front();
                checks++;
                if (led_en_o !== m.en || seg_o !== m.seg ||
                    dp_o !== m.dp || frame_o !== m.fr) begin
                    errors++;
                    $display("FAIL scan n=%0d: got en=%b seg=%h dp=%b fr=%b, expected en=%b seg=%h dp=%b fr=%b",
                             n, led_en_o, seg_o, dp_o, frame_o,
                             m.en, m.seg, m.dp, m.fr);
                end
            end
        end
    end

    task automatic check_dark(input string name);
        checks++;
        if (led_en_o !== 4'hF || seg_o !== 7'h7F ||
            dp_o !== 1'b1 || frame_o !== 1'b0) begin
            errors++;
            $display("FAIL %s: got en=%b seg=%h dp=%b fr=%b, expected en=1111 seg=7f dp=1 fr=0",
                     name, led_en_o, seg_o, dp_o, frame_o);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk_1khz);
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p);
        data_i = d;
        dp_i   = p;
        load_i = 1'b1;
        @(negedge clk_1khz);
        load_i = 1'b0;
    endtask

    task automatic wait_pos(input int target, input string name);
        for (int i = 0; i < 32 && (n % 16) != target; i++)
            @(negedge clk_1khz);
        checks++;
        if ((n % 16) != target) begin
            errors++;
            $display("FAIL %s: got pos=%0d, expected pos=%0d",
                     name, n % 16, target);
        end
    endtask

    initial begin
        rst        = 1'b0;
        load_i     = 1'b0;
        data_i     = '0;
        dp_i       = '0;
        bright_i   = 2'd3;
        blink_i    = '0;
        blank_lz_i = 1'b0;

        #3 rst = 1'b1;
        #1 check_dark("por_dark");
        idle(2);
        check_dark("reset_hold");
        rst = 1'b0;

        load(16'h1234, 4'b0000);
        idle(48);

        bright_i = 2'd0;
        idle(32);
        bright_i = 2'd3;

        idle(5);
        load(16'hAAAA, 4'b0000);
        idle(40);

        wait_pos(15, "wrap_align");
        load(16'h5A3C, 4'b0010);
        idle(32);

        blank_lz_i = 1'b1;
        load(16'h0050, 4'b0000);
        idle(40);
        load(16'h0000, 4'b0000);
        idle(40);
        blank_lz_i = 1'b0;

        load(16'h1234, 4'b0001);
        blink_i = 4'b0001;
        idle(16 * 9);
        blink_i = 4'b0000;

        repeat (200) begin
            bright_i   = 2'($urandom);
            blink_i    = 4'($urandom);
            blank_lz_i = 1'($urandom);
            if ($urandom_range(0, 3) == 0)
                load(16'($urandom), 4'($urandom));
            else
                idle($urandom_range(1, 8));
        end
        bright_i   = 2'd3;
        blink_i    = '0;
        blank_lz_i = 1'b0;
        idle(32);

        wait_pos(3, "pend_align");
        load(16'h9876, 4'b1111);
        idle(2);
        @(posedge clk_1khz);
        #2 rst = 1'b1;
        #1 check_dark("rst_async");
        idle(3);
        check_dark("rst_held");
        rst = 1'b0;
        idle(64);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
